// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external shift/add/sub ALU between two requesters.
// Optional grant counters: define ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int DATA_W  = 4,
  parameter int SHAMT_W = 2
`ifdef ALU_ARB_STATS_EN
  ,
  parameter int CNT_W   = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*DATA_W-1:0]  req_a,
  input  logic [2*DATA_W-1:0]  req_b,
  input  logic [2*SHAMT_W-1:0] req_c,
  input  logic [3:0]           req_op,
  output logic [DATA_W-1:0]    alu_inA,
  output logic [DATA_W-1:0]    alu_inB,
  output logic [SHAMT_W-1:0]   alu_inC,
  output logic [1:0]           alu_op,
  input  logic [DATA_W-1:0]    alu_ans,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic [DATA_W-1:0]    rsp_data,
  input  logic                 rsp_ready
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0]     gnt_cnt0,
  output logic [CNT_W-1:0]     gnt_cnt1
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last;
  logic                r_id;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [SHAMT_W-1:0]  r_c;
  logic [1:0]          r_op;
  logic                w_gnt;
  logic                w_hs;
  logic                w_rsp_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // A lone requester wins outright; a tie goes to the one not served last.
  always_comb begin
    w_gnt = req_valid[1];
    if (req_valid == 2'b11) w_gnt = ~r_last;
    w_hs      = (r_state == S_IDLE) && req_valid[w_gnt];
    w_rsp_hs  = (r_state == S_RESP) && rsp_ready;
    req_ready = 2'b00;
    if (w_hs) req_ready = w_gnt ? 2'b10 : 2'b01;
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_hs) w_next = S_EXEC;
      S_EXEC:  w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_id    <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_op    <= '0;
    end else begin
      if (w_hs) begin
        r_a  <= req_a[int'(w_gnt)*DATA_W +: DATA_W];
        r_b  <= req_b[int'(w_gnt)*DATA_W +: DATA_W];
        r_c  <= req_c[int'(w_gnt)*SHAMT_W +: SHAMT_W];
        r_op <= req_op[int'(w_gnt)*2 +: 2];
        r_id <= w_gnt;
      end
      if (r_state == S_EXEC) begin
        r_data  <= alu_ans;
        r_valid <= 1'b1;
      end
      if (w_rsp_hs) begin
        r_valid <= 1'b0;
        r_last  <= r_id;
      end
    end
  end

  assign alu_inA   = r_a;
  assign alu_inB   = r_b;
  assign alu_inC   = r_c;
  assign alu_op    = r_op;
  assign rsp_valid = r_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (w_hs) begin
      if (w_gnt) r_cnt1 <= r_cnt1 + 1'b1;
      else       r_cnt0 <= r_cnt0 + 1'b1;
    end
  end

  assign gnt_cnt0 = r_cnt0;
  assign gnt_cnt1 = r_cnt1;
`endif

endmodule
